average_filter: RTL and testbench

AVERAGE_FILTER -- requirements
Module: average_filter

---
 rtl/average_filter.sv | 69 ++++++
 tb/tb_average_filter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/average_filter.sv
// Two-stage pipelined 2-tap moving average: y[n] = floor((x[n] + x[n-1]) / 2).
// Stage 1 registers the widened sum; stage 2 registers the arithmetic half.
module average_filter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_ce,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         o_ce,
  output logic                         o_sum_ce,
  output logic signed [DATA_WIDTH-1:0] o_last_sample,
  output logic signed [DATA_WIDTH:0]   o_sum_ff
);

  logic signed [DATA_WIDTH:0]   sum_r;
  logic signed [DATA_WIDTH-1:0] last_sample_r;
  logic                         sum_ce_r;
  logic signed [DATA_WIDTH-1:0] data_out_r;
  logic                         o_ce_r;
  logic signed [DATA_WIDTH:0]   next_sum_s;
  logic signed [DATA_WIDTH:0]   half_s;

  function automatic logic signed [DATA_WIDTH:0] sext(input logic signed [DATA_WIDTH-1:0] v);
    return {v[DATA_WIDTH-1], v};
  endfunction

  // Widened sum of the incoming sample and its predecessor, and the floored half of the stored sum.
  always_comb begin
    next_sum_s = sext(data_in) + sext(last_sample_r);
    half_s     = sum_r >>> 1;
  end

  // Stage 1: accept a sample, capture the sum and remember the sample for the next pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_r         <= '0;
      last_sample_r <= '0;
      sum_ce_r      <= 1'b0;
    end else if (i_ce) begin
      sum_r         <= next_sum_s;
      last_sample_r <= data_in;
      sum_ce_r      <= 1'b1;
    end else begin
      sum_ce_r      <= 1'b0;
    end
  end

  // Stage 2: the half of a (DATA_WIDTH+1)-bit sum always fits back into DATA_WIDTH bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_r <= '0;
      o_ce_r     <= 1'b0;
    end else if (sum_ce_r) begin
      data_out_r <= half_s[DATA_WIDTH-1:0];
      o_ce_r     <= 1'b1;
    end else begin
      o_ce_r     <= 1'b0;
    end
  end

  assign data_out      = data_out_r;
  assign o_ce          = o_ce_r;
  assign o_sum_ce      = sum_ce_r;
  assign o_last_sample = last_sample_r;
  assign o_sum_ff      = sum_r;

endmodule

// File: tb/tb_average_filter.sv
// Self-checking bench for average_filter: directed sequences plus random stimulus
// compared against an arithmetic reference of the floored 2-tap average.
module tb_average_filter;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 i_ce;
  logic signed [DW-1:0] data_in;
  logic signed [DW-1:0] data_out;
  logic                 o_ce;
  logic                 o_sum_ce;
  logic signed [DW-1:0] o_last_sample;
  logic signed [DW:0]   o_sum_ff;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: previous accepted sample, pending average, expected outputs.
  int m_last, m_pend_avg, exp_sum, exp_out;
  bit m_pend, exp_sum_ce, exp_oce;

  average_filter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .i_ce(i_ce), .data_in(data_in),
    .data_out(data_out), .o_ce(o_ce), .o_sum_ce(o_sum_ce),
    .o_last_sample(o_last_sample), .o_sum_ff(o_sum_ff)
  );

  always #5 clk = ~clk;

  function automatic int floor_half(input int s);
    if (s >= 0) return s / 2;
    else        return -((-s + 1) / 2);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_last = 0; m_pend_avg = 0; m_pend = 1'b0;
    exp_sum = 0; exp_out = 0; exp_sum_ce = 1'b0; exp_oce = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":o_sum_ce"}, o_sum_ce, exp_sum_ce);
    chk({tag, ":o_sum_ff"}, o_sum_ff, exp_sum);
    chk({tag, ":o_last_sample"}, o_last_sample, m_last);
    chk({tag, ":o_ce"}, o_ce, exp_oce);
    chk({tag, ":data_out"}, data_out, exp_out);
  endtask

  // Drive one cycle from a negedge, advance the reference at the edge, check at the next negedge.
  task automatic step(input logic ce, input logic signed [DW-1:0] d, input string tag);
    int s;
    i_ce = ce; data_in = d;
    @(posedge clk);
    exp_oce = m_pend;
    if (m_pend) exp_out = m_pend_avg;
    exp_sum_ce = ce;
    if (ce) begin
      s = int'(d) + m_last;
      exp_sum = s;
      m_pend_avg = floor_half(s);
      m_last = int'(d);
      m_pend = 1'b1;
    end else begin
      m_pend = 1'b0;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  logic signed [DW-1:0] seq_in  [8] = '{-8'sd20, 8'sd30, -8'sd40, 8'sd50, 8'sd0, 8'sd100, -8'sd127, 8'sd127};
  logic signed [DW-1:0] seq_out [8] = '{-8'sd5, 8'sd5, -8'sd5, 8'sd5, 8'sd25, 8'sd50, -8'sd14, 8'sd0};
  logic signed [DW-1:0] seq_sum [8] = '{-8'sd10, 8'sd10, -8'sd10, 8'sd10, 8'sd50, 8'sd100, -8'sd27, 8'sd0};

  initial begin
    reset_n = 1'b0; i_ce = 1'b0; data_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;

    // Two consecutive accepts of 10: results 5 then 10.
    step(1'b1, 8'sd10, "ce10_a");
    step(1'b1, 8'sd10, "ce10_b");
    chk("first_avg", data_out, 32'sd5);
    step(1'b0, 8'sd0, "drain");
    chk("repeat_avg", data_out, 32'sd10);

    for (int i = 0; i < 8; i++) begin
      step(1'b1, seq_in[i], "seq_acc");
      chk("seq_sum", o_sum_ff, seq_sum[i]);
      step(1'b0, 8'sd0, "seq_out");
      chk("seq_data_out", data_out, seq_out[i]);
      chk("seq_o_ce", o_ce, 1'b1);
    end

    step(1'b1, 8'sd127, "trunc_a");
    step(1'b1, -8'sd60, "trunc_b");
    step(1'b0, 8'sd0, "trunc_c");
    chk("trunc_33", data_out, 32'sd33);
    step(1'b1, 8'sd100, "floor_a");
    step(1'b1, -8'sd127, "floor_b");
    step(1'b0, 8'sd0, "floor_c");
    chk("floor_m14", data_out, -32'sd14);

    // Mid-stream reset: samples in flight must be discarded immediately.
    step(1'b1, 8'sd55, "pre_rst_a");
    i_ce = 1'b1; data_in = 8'sd77;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    @(negedge clk);
    check_all("rst_held");
    reset_n = 1'b1;
    step(1'b0, 8'sd0, "post_rst_idle");
    step(1'b1, 8'sd10, "post_rst_10");
    step(1'b0, 8'sd0, "post_rst_out");
    chk("post_rst_avg", data_out, 32'sd5);

    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)), "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
